// File: rtl/equiv_pkg.sv
// equiv_pkg: shared types, widths and stimulus helpers for the equivalence-check sequencer
package equiv_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam int W0_W = 22;
  localparam int W1_W = 6;
  localparam int W2_W = 15;
  localparam int W3_W = 21;
  localparam int W4_W = 12;
  localparam int DUT_Y_W = 91;
  localparam int STIM_W = 76;
  localparam int W0_LO = 54;
  localparam int W1_LO = 48;
  localparam int W2_LO = 33;
  localparam int W3_LO = 12;
  localparam int W4_LO = 0;
  function automatic logic [STIM_W-1:0] stim_of(input logic [31:0] l);
    return {l[31:20], l, l};
  endfunction
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_POLY : 32'h0);
  endfunction
endpackage

// File: rtl/equiv_lfsr32.sv
// equiv_lfsr32: 32-bit Galois LFSR with seed load; a zero seed becomes 1 so it never locks up
module equiv_lfsr32 import equiv_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] seed,
  output logic [31:0] state
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= 32'd1;
    else if (load) state <= (seed == 32'd0) ? 32'd1 : seed;
    else if (en) state <= lfsr_next(state);
endmodule

// File: rtl/equiv_check_ctrl.sv
// equiv_check_ctrl: issues LFSR vectors to two DUT instances, compares their outputs
// LAT cycles later, and reports mismatch count / first failing index via start/done.
module equiv_check_ctrl import equiv_pkg::*; #(
  parameter int Y_W   = DUT_Y_W,
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic [31:0]      seed,
  output logic [W0_W-1:0]  wire0,
  output logic [W1_W-1:0]  wire1,
  output logic [W2_W-1:0]  wire2,
  output logic [W3_W-1:0]  wire3,
  output logic [W4_W-1:0]  wire4,
  input  logic [Y_W-1:0]   y_1,
  input  logic [Y_W-1:0]   y_2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx
);
  state_t state, state_nx;
  logic [CNT_W-1:0] nv, issued_cnt;
  logic [3:0] drain_cnt;
  logic [31:0] lfsr;
  logic [STIM_W-1:0] stim;
  logic [LAT-1:0] vld_pipe;
  logic [LAT-1:0][CNT_W-1:0] idx_pipe;
  logic go, issue, kill, last_vec, drain_end, cmp_fail;
  assign go = (state == IDLE) && start;
  assign busy = (state == LOAD) || (state == RUN) || (state == DRAIN);
  assign kill = busy && abort;
  assign issue = (state == RUN) && !abort;
  assign last_vec = issued_cnt == nv - CNT_W'(1);
  assign drain_end = drain_cnt == 4'(LAT - 1);
  assign cmp_fail = vld_pipe[LAT-1] && (y_1 != y_2);
  assign stim = stim_of(lfsr);
  equiv_lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (go),
    .en    (issue),
    .seed  (seed),
    .state (lfsr)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? LOAD : IDLE;
      LOAD:    state_nx = abort ? IDLE : (nv == '0) ? DONE : RUN;
      RUN:     state_nx = abort ? IDLE : last_vec ? DRAIN : RUN;
      DRAIN:   state_nx = abort ? IDLE : drain_end ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      nv <= '0;
      issued_cnt <= '0;
      drain_cnt <= '0;
      wire0 <= '0;
      wire1 <= '0;
      wire2 <= '0;
      wire3 <= '0;
      wire4 <= '0;
    end else begin
      if (go) nv <= num_vectors;
      if (go) issued_cnt <= '0;
      else if (issue) issued_cnt <= issued_cnt + CNT_W'(1);
      if (issue) begin
        wire0 <= stim[W0_LO +: W0_W];
        wire1 <= stim[W1_LO +: W1_W];
        wire2 <= stim[W2_LO +: W2_W];
        wire3 <= stim[W3_LO +: W3_W];
        wire4 <= stim[W4_LO +: W4_W];
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 4'd1 : 4'd0;
    end
  // Valid/index travel together so each compare knows which vector it judges
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe <= kill ? '0 : LAT'({vld_pipe, issue});
      idx_pipe <= (LAT*CNT_W)'({idx_pipe, issued_cnt});
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      done <= 1'b0;
      pass <= 1'b0;
      mismatch_cnt <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      done <= state == DONE;
      if (state == DONE) pass <= mismatch_cnt == '0;
      if (cmp_fail && mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
      if (cmp_fail && !first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_idx <= idx_pipe[LAT-1];
      end
      if (go) begin
        pass <= 1'b0;
        mismatch_cnt <= '0;
        first_fail_valid <= 1'b0;
        first_fail_idx <= '0;
      end
    end
endmodule

// File: tb/tb_equiv_check_ctrl.sv
// tb_equiv_check_ctrl: randomized runs against a timeline model of the sequencer,
// plus hand-computed pins for the first LFSR vectors and latencies.
module tb_equiv_check_ctrl;
  localparam int LAT = 2;
  localparam int CNT_W = 4;
  localparam int YW = 91;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [CNT_W-1:0] num_vectors = 0;
  logic [31:0] seed = 0;
  logic [21:0] wire0;
  logic [5:0] wire1;
  logic [14:0] wire2;
  logic [20:0] wire3;
  logic [11:0] wire4;
  logic [YW-1:0] y_1 = 0, y_2 = 0;
  logic busy, done, pass, first_fail_valid;
  logic [CNT_W-1:0] mismatch_cnt, first_fail_idx;
  int n_cmp = 0, n_fail = 0;
  int t = 0, r_nv = 0, r_ta = 0, r_tds = 0, done_t = -1, pin = 0;
  bit active = 0;
  bit bad [16];
  logic [31:0] r_seed = 0;
  logic [75:0] prev_w = 0;
  always #5 clk = ~clk;
  equiv_check_ctrl #(.Y_W(YW), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_vectors(num_vectors), .seed(seed),
    .wire0(wire0), .wire1(wire1), .wire2(wire2), .wire3(wire3), .wire4(wire4),
    .y_1(y_1), .y_2(y_2), .busy(busy), .done(done), .pass(pass),
    .mismatch_cnt(mismatch_cnt), .first_fail_valid(first_fail_valid),
    .first_fail_idx(first_fail_idx)
  );
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask
  function automatic logic [31:0] step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
  endfunction
  function automatic logic [75:0] vec(input logic [31:0] s, input int k);
    logic [31:0] l;
    l = (s == 0) ? 32'd1 : s;
    for (int i = 0; i < k; i++) l = step(l);
    return {l[31:20], l, l};
  endfunction
  function automatic int imin(input int a, input int b);
    return a < b ? a : b;
  endfunction
  // vectors registered by the end of edge tt (edges 2..nv+1, none at or after abort)
  function automatic int n_iss(input int tt);
    int m;
    m = imin(imin(tt, r_ta - 1), r_nv + 1) - 1;
    return m < 0 ? 0 : m;
  endfunction
  // vectors whose compare edge (issue edge + LAT) has passed, abort edge included
  function automatic int n_cmpd(input int tt);
    int m;
    m = imin(tt, r_ta) - 1 - LAT;
    return m < 0 ? 0 : imin(m, r_nv);
  endfunction
  function automatic logic [75:0] wires_at(input int tt);
    int ni;
    ni = n_iss(tt);
    return ni > 0 ? vec(r_seed, ni - 1) : prev_w;
  endfunction
  int c_nc, c_mm, c_fi;
  bit c_fin;
  always @(negedge clk) if (active) begin
    c_nc = n_cmpd(t);
    c_mm = 0;
    c_fi = -1;
    for (int k = 0; k < c_nc; k++) if (bad[k]) begin
      c_mm++;
      if (c_fi < 0) c_fi = k;
    end
    c_fin = r_ta > r_tds && t >= r_tds + 1;
    chk("busy", busy, t < r_tds && t < r_ta);
    chk("done", done, t == r_tds + 1 && r_ta > r_tds);
    chk("pass", pass, c_fin && c_mm == 0);
    chk("wires", {wire0, wire1, wire2, wire3, wire4}, wires_at(t));
    chk("mismatch_cnt", mismatch_cnt, c_mm > 15 ? 15 : c_mm);
    chk("first_fail_valid", first_fail_valid, c_fi >= 0);
    chk("first_fail_idx", first_fail_idx, c_fi >= 0 ? c_fi : 0);
    if (done) done_t = t;
  end
  task automatic chk_zero(input string name);
    chk(name, {busy, done, pass, first_fail_valid, mismatch_cnt, first_fail_idx}, 0);
    chk({name, "_wires"}, {wire0, wire1, wire2, wire3, wire4}, 0);
  endtask
  // mode: 0 none bad, 1 random, 2 all bad, 3 only vector 1 bad
  task automatic run(input logic [31:0] s, input int nv, input int ta, input int rst_at, input int mode);
    logic [95:0] rr;
    logic [YW-1:0] mask;
    int k, fin;
    for (int i = 0; i < 16; i++)
      bad[i] = mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0) || (mode == 3 && i == 1);
    mask = YW'(1) << $urandom_range(0, YW - 1);
    r_seed = s;
    r_nv = nv;
    r_tds = nv == 0 ? 1 : nv + 1 + LAT;
    r_ta = ta < 0 ? 1 << 30 : ta;
    fin = imin(r_tds + 1, r_ta);
    done_t = -1;
    start = 1;
    seed = s;
    num_vectors = CNT_W'(nv);
    @(posedge clk);
    t = 0;
    active = 1;
    while (t < fin + 1) begin
      #1;
      if (pin == 1 && t == 2) begin
        chk("pin_v0_w0", wire0, 22'h0);
        chk("pin_v0_w1", wire1, 6'h0);
        chk("pin_v0_w2", wire2, 15'h0);
        chk("pin_v0_w3", wire3, 21'h100000);
        chk("pin_v0_w4", wire4, 12'h001);
      end
      if (pin == 2 && t == 3) begin
        chk("pin_v1_w0", wire0, 22'h200A00);
        chk("pin_v1_w1", wire1, 6'h20);
        chk("pin_v1_w2", wire2, 15'h0001);
        chk("pin_v1_w3", wire3, 21'h180200);
        chk("pin_v1_w4", wire4, 12'h003);
      end
      if (t == rst_at) begin
        active = 0;
        #2 rst_n = 0;
        #1 chk_zero("async_reset");
        start = 0;
        abort = 0;
        @(negedge clk);
        rst_n = 1;
        prev_w = 0;
        return;
      end
      seed = $urandom;
      num_vectors = CNT_W'($urandom);
      rr = {$urandom, $urandom, $urandom};
      y_1 = rr[YW-1:0];
      k = t + 1 - 2 - LAT;
      y_2 = (k >= 0 && k < r_nv && k + 2 < r_ta && t + 1 <= r_ta && bad[k]) ? y_1 ^ mask : y_1;
      abort = t + 1 == r_ta;
      start = (t + 1 <= fin) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    active = 0;
    prev_w = wires_at(t);
    start = 0;
    abort = 0;
  endtask
  initial begin
    #2 chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    pin = 1;
    run(32'd1, 1, -1, -1, 0);
    chk("t1_done_latency", done_t, 5);
    chk("t1_pass", pass, 1);
    pin = 2;
    run(32'd1, 3, -1, -1, 3);
    chk("t2_mismatch_cnt", mismatch_cnt, 1);
    chk("t2_ffi", {first_fail_valid, first_fail_idx}, {1'b1, 4'd1});
    chk("t2_pass", pass, 0);
    pin = 0;
    run(32'd5, 0, -1, -1, 0);
    chk("t3_done_latency", done_t, 2);
    chk("t3_pass", pass, 1);
    run($urandom, 15, -1, -1, 2);
    chk("t4_saturated", mismatch_cnt, 15);
    chk("t4_ffi", first_fail_idx, 0);
    run($urandom, 10, 5, -1, 2);
    chk("t5_abort_held", mismatch_cnt, 2);
    chk("t5_no_done", done_t, -1);
    run($urandom, 6, -1, -1, 0);
    run(32'd0, 4, -1, 6, 1);
    pin = 1;
    run(32'd0, 4, -1, -1, 1);
    pin = 0;
    for (int i = 0; i < 30; i++) begin
      int nv, ta;
      nv = $urandom_range(0, 15);
      ta = $urandom_range(0, 9) < 3 ? $urandom_range(1, nv == 0 ? 1 : nv + 1 + LAT) : -1;
      run($urandom_range(0, 3) == 0 ? 32'd0 : $urandom, nv, ta, -1, 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
